// File: rtl/fsm_pkg.sv
// Shared types and default constants for the input debouncer and the sequence FSMs it feeds.
package fsm_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_chain.sv
// Generic N-flop synchroniser: d is shifted through STAGES flops and leaves as q.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
    end else begin
      s_q <= {s_q[STAGES-2:0], d};
    end
  end

  assign q = s_q[STAGES-1];

endmodule

// File: rtl/fsm_input_debounce.sv
// Synchronises and debounces a raw pin into a clean level X with one-cycle rise/fall pulses.
module fsm_input_debounce
  import fsm_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic X,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sq;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, rise_q, fall_q;
  logic             rise_d, fall_d;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (sq)
  );

  // cnt counts consecutive samples agreeing with the candidate level; it is
  // reloaded on every state entry so it can never pass CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sq) begin
          state_d = S_RISE;
          cnt_d   = CNT_ONE;
        end
      end
      S_RISE: begin
        if (!sq) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sq) begin
          state_d = S_FALL;
          cnt_d   = CNT_ONE;
        end
      end
      S_FALL: begin
        if (sq) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // X is registered from the next state so it equals the Moore decode of
  // state_q while changing only just after the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= (state_d == S_HIGH) || (state_d == S_FALL);
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign X    = x_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_fsm_input_debounce.sv
// Directed plus randomized stimulus for fsm_input_debounce, checked against a run-length model.
module tb_fsm_input_debounce;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic x_o, rise_o, fall_o;

  always #50 clk = ~clk;

  fsm_input_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .X     (x_o),
    .rise  (rise_o),
    .fall  (fall_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  int rise_seen = 0;
  int fall_seen = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // X adopts the synchronised level once that level has been seen on DEB
  // consecutive edges; the synchroniser is a plain SYNC-deep delay line.
  logic m_pipe[SYNC];
  logic m_x = 1'b0;
  logic m_last = 1'b0;
  int   m_run = 0;

  task automatic model_edge();
    logic sq, nx;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_x = 1'b0; m_last = 1'b0; m_run = 0;
      exp_q.push_back(3'b000);
    end else begin
      sq = m_pipe[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = din;
      m_run  = (sq == m_last) ? m_run + 1 : 1;
      m_last = sq;
      nx = (sq != m_x && m_run >= DEB) ? sq : m_x;
      exp_q.push_back({nx, (!m_x && nx), (m_x && !nx)});
      m_x = nx;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic d, input logic r);
    logic [2:0] e;
    @(negedge clk);
    din = d;
    reset = r;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("x", x_o, e[2]);
    check("rise", rise_o, e[1]);
    check("fall", fall_o, e[0]);
    check("rise_fall_excl", rise_o & fall_o, 1'b0);
    check("x_known", $isunknown({x_o, rise_o, fall_o}), 1'b0);
    if (rise_o === 1'b1) rise_seen++;
    if (fall_o === 1'b1) fall_seen++;
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first, r0, f0, len;
    logic v;

    // 1: reset with din high
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("reset_x", x_o, 1'b0);
    hold(1'b0, 8);

    // 2: clean rise, X must appear on the (SYNC+DEB)-th edge counting the first sample
    first = -1; r0 = rise_seen;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (first < 0 && x_o === 1'b1) first = i;
    end
    check_int("rise_latency", first, SYNC + DEB);
    check_int("rise_pulses", rise_seen - r0, 1);

    // 3: glitch shorter than DEB is rejected
    hold(1'b0, 10);
    r0 = rise_seen;
    hold(1'b1, DEB - 1);
    hold(1'b0, 10);
    check_int("glitch_rise_pulses", rise_seen - r0, 0);
    check("glitch_x", x_o, 1'b0);

    // 4: bounce on release
    hold(1'b1, 10);
    f0 = fall_seen;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    hold(1'b0, 10);
    check_int("bounce_fall_pulses", fall_seen - f0, 1);
    check("bounce_x", x_o, 1'b0);

    // 5: reset mid-qualify forces a full requalification
    r0 = rise_seen;
    hold(1'b1, 3);
    step(1'b1, 1'b1);
    check_int("midreset_rise_pulses", rise_seen - r0, 0);
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (first < 0 && x_o === 1'b1) first = i;
    end
    check_int("midreset_latency", first, SYNC + DEB);

    // 6: integration pattern
    hold(1'b0, 6); hold(1'b1, 6); hold(1'b1, 6); hold(1'b0, 6); hold(1'b0, 6);
    check("pattern_x", x_o, 1'b0);

    // randomized runs, occasional reset
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        step(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        v   = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 8);
        hold(v, len);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #(100 * 20000);
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

endmodule
